// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its write/read scheduler.
package instr_register_pkg;

    localparam int DEPTH   = 32;
    localparam int MAX_REQ = 8;

    typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef logic signed [31:0]          operand_t;
    typedef logic [$clog2(DEPTH)-1:0]    address_t;
    typedef logic [$clog2(MAX_REQ)-1:0]  req_idx_t;

    typedef enum logic [1:0] {IDLE, READ, DONE} sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last requester that was granted.
module rr_arbiter
    import instr_register_pkg::req_idx_t;
#(
    parameter int NUM_REQ = 4
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    req_idx_t           last_winner;
    req_idx_t           win_idx;
    logic               found;
    logic [NUM_REQ-1:0] rot;

    // Rotating the doubled request vector puts last_winner+1 at bit 0, so the lowest set bit wins.
    always_comb begin
        rot     = NUM_REQ'({req, req} >> (int'(last_winner) + 1));
        found   = 1'b0;
        win_idx = last_winner;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found   = 1'b1;
                win_idx = req_idx_t'((int'(last_winner) + 1 + j) % NUM_REQ);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = found && (win_idx == req_idx_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= req_idx_t'(NUM_REQ - 1);
        end else if (advance && found) begin
            last_winner <= win_idx;
        end
    end

endmodule

// File: rtl/instr_register_sched.sv
// Write-port arbitration, pointer/count bookkeeping and in-order read-back for instr_register.
module instr_register_sched
    import instr_register_pkg::opcode_t, instr_register_pkg::operand_t,
           instr_register_pkg::address_t, instr_register_pkg::sched_state_t,
           instr_register_pkg::ZERO, instr_register_pkg::IDLE,
           instr_register_pkg::READ, instr_register_pkg::DONE;
#(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = instr_register_pkg::DEPTH,
    parameter bit WRAP_EN = 1'b0
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  opcode_t                req_opcode    [NUM_REQ],
    input  operand_t               req_operand_a [NUM_REQ],
    input  operand_t               req_operand_b [NUM_REQ],
    output logic [NUM_REQ-1:0]     req_grant,
    input  logic                   clear,
    input  logic                   rd_start,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output address_t               rd_index,
    output logic                   rd_done,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   load_en,
    output address_t               write_pointer,
    output address_t               read_pointer,
    output opcode_t                opcode,
    output operand_t               operand_a,
    output operand_t               operand_b
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam address_t      LAST_ADDR = address_t'(DEPTH - 1);

    sched_state_t  state;
    logic [CW-1:0] remaining;
    logic          clear_eff;
    logic          grant_ok;

    function automatic address_t next_addr(input address_t a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    // A replay in progress owns the pointers, so clear only acts while idle.
    assign clear_eff = clear && (state == IDLE);
    assign full      = (count == DEPTH_CNT);
    assign grant_ok  = !clear_eff && !(full && !WRAP_EN);
    assign load_en   = |req_grant;
    assign rd_index  = read_pointer;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid & {NUM_REQ{grant_ok}}),
        .advance (load_en),
        .grant   (req_grant)
    );

    always_comb begin
        opcode    = ZERO;
        operand_a = '0;
        operand_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_grant[i]) begin
                opcode    = req_opcode[i];
                operand_a = req_operand_a[i];
                operand_b = req_operand_b[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_eff) begin
            write_pointer <= '0;
            count         <= '0;
        end else if (load_en) begin
            write_pointer <= next_addr(write_pointer);
            if (count != DEPTH_CNT) begin
                count <= count + 1'b1;
            end
        end
    end

    // The replay length is snapshotted at start so concurrent writes never extend it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rd_valid     <= 1'b0;
            rd_done      <= 1'b0;
            read_pointer <= '0;
            remaining    <= '0;
        end else begin
            rd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        if (count != '0) begin
                            state        <= READ;
                            rd_valid     <= 1'b1;
                            remaining    <= count;
                            read_pointer <= (WRAP_EN && full) ? write_pointer : '0;
                        end else begin
                            state   <= DONE;
                            rd_done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_ready) begin
                        read_pointer <= next_addr(read_pointer);
                        remaining    <= remaining - 1'b1;
                        if (remaining == CW'(1)) begin
                            state    <= DONE;
                            rd_valid <= 1'b0;
                            rd_done  <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_register_sched.sv
// Scoreboard bench for instr_register_sched: one instance without and one with write wrap-around.
module tb_instr_register_sched;
    import instr_register_pkg::*;

    typedef struct packed {
        opcode_t  op;
        operand_t a;
        operand_t b;
        operand_t res;
    } ent_t;

    typedef struct {
        logic [3:0] g0;
        address_t   wp0;
        logic [5:0] cnt0;
        ent_t       d0;
        logic [3:0] g1;
        address_t   wp1;
        logic [5:0] cnt1;
    } wexp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    opcode_t    req_opcode    [4];
    operand_t   req_operand_a [4];
    operand_t   req_operand_b [4];
    logic       clear, rd_start, rd_ready;

    logic [3:0] g0, g1;
    logic       rd_valid0, rd_valid1, rd_done0, rd_done1, full0, full1, load_en0, load_en1;
    address_t   rd_index0, rd_index1, wp0, wp1, rp0, rp1;
    logic [5:0] count0, count1;
    opcode_t    op0, op1;
    operand_t   a0, b0, a1, b1;

    int    vectors = 0;
    int    miscompares = 0;
    int    m0_last, m0_wp, m0_count, m1_last, m1_wp, m1_count;
    ent_t  exp_mem0 [32];
    ent_t  tb_reg0  [32];
    wexp_t wq[$];
    int    rq[$];

    instr_register_sched #(.NUM_REQ(4), .DEPTH(32), .WRAP_EN(1'b0)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_opcode(req_opcode),
        .req_operand_a(req_operand_a), .req_operand_b(req_operand_b), .req_grant(g0),
        .clear(clear), .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid0),
        .rd_index(rd_index0), .rd_done(rd_done0), .full(full0), .count(count0),
        .load_en(load_en0), .write_pointer(wp0), .read_pointer(rp0),
        .opcode(op0), .operand_a(a0), .operand_b(b0)
    );

    instr_register_sched #(.NUM_REQ(4), .DEPTH(32), .WRAP_EN(1'b1)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_opcode(req_opcode),
        .req_operand_a(req_operand_a), .req_operand_b(req_operand_b), .req_grant(g1),
        .clear(clear), .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid1),
        .rd_index(rd_index1), .rd_done(rd_done1), .full(full1), .count(count1),
        .load_en(load_en1), .write_pointer(wp1), .read_pointer(rp1),
        .opcode(op1), .operand_a(a1), .operand_b(b1)
    );

    always #5 clk = ~clk;

    function automatic operand_t calc(opcode_t op, operand_t a, operand_t b);
        case (op)
            ZERO:    return '0;
            PASSA:   return a;
            PASSB:   return b;
            ADD:     return a + b;
            SUB:     return a - b;
            MULT:    return a * b;
            DIV:     return (b == 0) ? '0 : a / b;
            MOD:     return (b == 0) ? '0 : a % b;
            default: return '0;
        endcase
    endfunction

    // Stand-in for instr_register behind the WRAP_EN=0 instance.
    always @(posedge clk) begin
        if (load_en0) tb_reg0[wp0] <= {op0, a0, b0, calc(op0, a0, b0)};
    end

    function automatic int rr_pick(logic [3:0] v, int last);
        for (int k = 1; k <= 4; k++) begin
            int c = (last + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req_valid = '0;
        clear     = 1'b0;
        rd_start  = 1'b0;
        rd_ready  = 1'b0;
    endtask

    task automatic reset_model();
        m0_last = 3; m0_wp = 0; m0_count = 0;
        m1_last = 3; m1_wp = 0; m1_count = 0;
        wq.delete();
        rq.delete();
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        reset_model();
    endtask

    task automatic set_req(int i, opcode_t op, int a, int b);
        req_opcode[i]    = op;
        req_operand_a[i] = operand_t'(a);
        req_operand_b[i] = operand_t'(b);
    endtask

    // Drives one write cycle and pushes what both instances should do in it.
    task automatic drive_write(input logic [3:0] v, input logic clr);
        wexp_t e;
        int    w;
        req_valid = v;
        clear     = clr;
        e.g0 = '0; e.wp0 = address_t'(m0_wp); e.cnt0 = 6'(m0_count); e.d0 = '0;
        e.g1 = '0; e.wp1 = address_t'(m1_wp); e.cnt1 = 6'(m1_count);
        if (clr) begin
            m0_wp = 0; m0_count = 0;
        end else if (m0_count < DEPTH) begin
            w = rr_pick(v, m0_last);
            if (w >= 0) begin
                e.g0 = 4'(1 << w);
                e.d0 = {req_opcode[w], req_operand_a[w], req_operand_b[w],
                        calc(req_opcode[w], req_operand_a[w], req_operand_b[w])};
                exp_mem0[m0_wp] = e.d0;
                m0_last  = w;
                m0_wp    = (m0_wp + 1) % DEPTH;
                m0_count = m0_count + 1;
            end
        end
        if (clr) begin
            m1_wp = 0; m1_count = 0;
        end else begin
            w = rr_pick(v, m1_last);
            if (w >= 0) begin
                e.g1    = 4'(1 << w);
                m1_last = w;
                m1_wp   = (m1_wp + 1) % DEPTH;
                if (m1_count < DEPTH) m1_count = m1_count + 1;
            end
        end
        wq.push_back(e);
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        tick();
        @(negedge clk);
        vectors++;
        if (g0 !== 4'b0000 || load_en0 !== 1'b0 || wp0 !== 5'd0 || rp0 !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_ptrs: got grant=%b load_en=%b wp=%0d rp=%0d, expected 0000/0/0/0", g0, load_en0, wp0, rp0);
        end
        vectors++;
        if (count0 !== 6'd0 || full0 !== 1'b0 || rd_valid0 !== 1'b0 || rd_done0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got count=%0d full=%b rd_valid=%b rd_done=%b, expected 0/0/0/0", count0, full0, rd_valid0, rd_done0);
        end
        tick();
        reset = 1'b0;
        reset_model();
    endtask

    task automatic test_round_robin();
        wexp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, ADD, 10 * (i + 1), i + 1);
        for (int c = 0; c < 4; c++) begin
            drive_write(4'b1111, 1'b0);
            @(negedge clk);
            e = wq.pop_front();
            vectors++;
            if (g0 !== e.g0 || wp0 !== e.wp0 || load_en0 !== 1'b1 || count0 !== e.cnt0) begin
                miscompares++;
                $display("[TB] FAIL rr_grant[%0d]: got grant=%b wp=%0d load_en=%b count=%0d, expected grant=%b wp=%0d load_en=1 count=%0d",
                         c, g0, wp0, load_en0, count0, e.g0, e.wp0, e.cnt0);
            end
            vectors++;
            if (op0 !== e.d0.op || a0 !== e.d0.a || b0 !== e.d0.b) begin
                miscompares++;
                $display("[TB] FAIL rr_data[%0d]: got %s/%0d/%0d, expected %s/%0d/%0d", c, op0.name(), a0, b0, e.d0.op.name(), e.d0.a, e.d0.b);
            end
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        vectors++;
        if (count0 !== 6'd4 || g0 !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL rr_count: got count=%0d grant=%b, expected count=4 grant=0000", count0, g0);
        end
        tick();
    endtask

    task automatic test_single_req();
        wexp_t e;
        ent_t  want;
        do_reset();
        set_req(2, ADD, 5, 7);
        drive_write(4'b0100, 1'b0);
        @(negedge clk);
        e = wq.pop_front();
        vectors++;
        if (g0 !== 4'b0100 || load_en0 !== 1'b1 || wp0 !== 5'd0 || op0 !== ADD || a0 !== 32'sd5 || b0 !== 32'sd7) begin
            miscompares++;
            $display("[TB] FAIL single_req: got grant=%b load_en=%b wp=%0d %s/%0d/%0d, expected 0100/1/0 ADD/5/7",
                     g0, load_en0, wp0, op0.name(), a0, b0);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        want.op = ADD; want.a = 32'sd5; want.b = 32'sd7; want.res = 32'sd12;
        vectors++;
        if (tb_reg0[0] !== want || e.d0 !== want) begin
            miscompares++;
            $display("[TB] FAIL single_entry0: got %s/%0d/%0d/%0d, expected ADD/5/7/12",
                     tb_reg0[0].op.name(), tb_reg0[0].a, tb_reg0[0].b, tb_reg0[0].res);
        end
        tick();
    endtask

    task automatic test_full_and_wrap();
        wexp_t e;
        int    exp_idx;
        do_reset();
        for (int c = 0; c < 33; c++) begin
            for (int i = 0; i < 4; i++) begin
                set_req(i, opcode_t'(4'($urandom_range(0, 7))), int'($urandom_range(0, 1000)), int'($urandom_range(1, 50)));
            end
            drive_write(4'($urandom_range(1, 15)), 1'b0);
            @(negedge clk);
            e = wq.pop_front();
            vectors++;
            if (g0 !== e.g0 || wp0 !== e.wp0 || count0 !== e.cnt0 || load_en0 !== |e.g0) begin
                miscompares++;
                $display("[TB] FAIL fill0[%0d]: got grant=%b wp=%0d count=%0d, expected grant=%b wp=%0d count=%0d",
                         c, g0, wp0, count0, e.g0, e.wp0, e.cnt0);
            end
            if (e.g0 != 4'b0000) begin
                vectors++;
                if (op0 !== e.d0.op || a0 !== e.d0.a || b0 !== e.d0.b) begin
                    miscompares++;
                    $display("[TB] FAIL fill0_data[%0d]: got %0d/%0d, expected %0d/%0d", c, a0, b0, e.d0.a, e.d0.b);
                end
            end
            vectors++;
            if (g1 !== e.g1 || wp1 !== e.wp1 || count1 !== e.cnt1) begin
                miscompares++;
                $display("[TB] FAIL fill1[%0d]: got grant=%b wp=%0d count=%0d, expected grant=%b wp=%0d count=%0d",
                         c, g1, wp1, count1, e.g1, e.wp1, e.cnt1);
            end
            if (c == 32) begin
                vectors++;
                if (g0 !== 4'b0000 || load_en0 !== 1'b0 || full0 !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL full_block: got grant=%b load_en=%b full=%b, expected 0000/0/1", g0, load_en0, full0);
                end
                vectors++;
                if (load_en1 !== 1'b1 || wp1 !== 5'd0) begin
                    miscompares++;
                    $display("[TB] FAIL wrap_grant: got load_en=%b wp=%0d, expected 1/0", load_en1, wp1);
                end
            end
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        vectors++;
        if (count0 !== 6'd32 || full0 !== 1'b1 || count1 !== 6'd32 || full1 !== 1'b1 || wp1 !== 5'd1 || wp0 !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL full_state: got count0=%0d full0=%b count1=%0d full1=%b wp1=%0d wp0=%0d, expected 32/1/32/1/1/0",
                     count0, full0, count1, full1, wp1, wp0);
        end

        // Full replay from this state: oldest-first on the wrapping instance.
        rd_start = 1'b1;
        for (int k = 0; k < 32; k++) rq.push_back(k);
        tick();
        rd_start = 1'b0;
        rd_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            exp_idx = rq.pop_front();
            vectors++;
            if (rd_valid0 !== 1'b1 || rd_index0 !== address_t'(exp_idx) || rp0 !== address_t'(exp_idx)) begin
                miscompares++;
                $display("[TB] FAIL replay0_idx[%0d]: got valid=%b idx=%0d rp=%0d, expected 1/%0d", k, rd_valid0, rd_index0, rp0, exp_idx);
            end
            vectors++;
            if (tb_reg0[rd_index0] !== exp_mem0[exp_idx]) begin
                miscompares++;
                $display("[TB] FAIL replay0_data[%0d]: got a=%0d b=%0d, expected a=%0d b=%0d",
                         k, tb_reg0[rd_index0].a, tb_reg0[rd_index0].b, exp_mem0[exp_idx].a, exp_mem0[exp_idx].b);
            end
            vectors++;
            if (rd_valid1 !== 1'b1 || rd_index1 !== address_t'((k + 1) % 32)) begin
                miscompares++;
                $display("[TB] FAIL replay1_idx[%0d]: got valid=%b idx=%0d, expected 1/%0d", k, rd_valid1, rd_index1, (k + 1) % 32);
            end
            tick();
        end
        rd_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (rd_done0 !== 1'b1 || rd_valid0 !== 1'b0 || rd_done1 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL replay_done: got done0=%b valid0=%b done1=%b, expected 1/0/1", rd_done0, rd_valid0, rd_done1);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rd_done0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL replay_done_pulse: got done=%b, expected 0", rd_done0);
        end
        tick();
    endtask

    task automatic test_read_handshake();
        wexp_t      e;
        logic [3:0] pat;
        int         exp_idx;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, SUB, 100 + i, 3 * i);
        for (int c = 0; c < 3; c++) begin
            drive_write(4'b1011, 1'b0);
            @(negedge clk);
            e = wq.pop_front();
            vectors++;
            if (g0 !== e.g0 || wp0 !== e.wp0) begin
                miscompares++;
                $display("[TB] FAIL hs_fill[%0d]: got grant=%b wp=%0d, expected grant=%b wp=%0d", c, g0, wp0, e.g0, e.wp0);
            end
            tick();
        end
        req_valid = '0;
        rd_start  = 1'b1;
        for (int k = 0; k < 3; k++) rq.push_back(k);
        tick();
        rd_start = 1'b0;
        pat = 4'b1101;
        for (int j = 0; j < 4; j++) begin
            rd_ready = pat[j];
            if (j == 3) drive_write(4'b0001, 1'b0);
            @(negedge clk);
            exp_idx = rq[0];
            vectors++;
            if (rd_valid0 !== 1'b1 || rd_index0 !== address_t'(exp_idx) || rd_done0 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL hs_idx[%0d]: got valid=%b idx=%0d done=%b, expected 1/%0d/0", j, rd_valid0, rd_index0, rd_done0, exp_idx);
            end
            if (pat[j]) begin
                void'(rq.pop_front());
                vectors++;
                if (tb_reg0[rd_index0] !== exp_mem0[exp_idx]) begin
                    miscompares++;
                    $display("[TB] FAIL hs_data[%0d]: got a=%0d res=%0d, expected a=%0d res=%0d",
                             j, tb_reg0[rd_index0].a, tb_reg0[rd_index0].res, exp_mem0[exp_idx].a, exp_mem0[exp_idx].res);
                end
            end
            if (j == 3) begin
                e = wq.pop_front();
                vectors++;
                if (load_en0 !== 1'b1 || wp0 !== 5'd3 || g0 !== e.g0) begin
                    miscompares++;
                    $display("[TB] FAIL hs_concurrent_write: got load_en=%b wp=%0d grant=%b, expected 1/3/%b", load_en0, wp0, g0, e.g0);
                end
            end
            tick();
        end
        req_valid = '0;
        rd_ready  = 1'b0;
        @(negedge clk);
        vectors++;
        if (rd_done0 !== 1'b1 || rd_valid0 !== 1'b0 || count0 !== 6'd4) begin
            miscompares++;
            $display("[TB] FAIL hs_done: got done=%b valid=%b count=%0d, expected 1/0/4", rd_done0, rd_valid0, count0);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rd_done0 !== 1'b0 || rd_valid0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hs_after: got done=%b valid=%b, expected 0/0", rd_done0, rd_valid0);
        end
        tick();
    endtask

    task automatic test_empty_read_and_clear();
        wexp_t e;
        do_reset();
        rd_start = 1'b1;
        @(negedge clk);
        vectors++;
        if (rd_valid0 !== 1'b0 || rd_done0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL empty_start: got valid=%b done=%b, expected 0/0", rd_valid0, rd_done0);
        end
        tick();
        rd_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (rd_done0 !== 1'b1 || rd_valid0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL empty_done: got done=%b valid=%b, expected 1/0", rd_done0, rd_valid0);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rd_done0 !== 1'b0 || rd_valid0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL empty_after: got done=%b valid=%b, expected 0/0", rd_done0, rd_valid0);
        end
        tick();

        for (int i = 0; i < 4; i++) set_req(i, MULT, i + 2, 4);
        for (int c = 0; c < 2; c++) begin
            drive_write(4'b0011, 1'b0);
            @(negedge clk);
            e = wq.pop_front();
            vectors++;
            if (g0 !== e.g0) begin
                miscompares++;
                $display("[TB] FAIL clr_fill[%0d]: got grant=%b, expected %b", c, g0, e.g0);
            end
            tick();
        end
        drive_write(4'b1111, 1'b1);
        @(negedge clk);
        e = wq.pop_front();
        vectors++;
        if (g0 !== 4'b0000 || load_en0 !== 1'b0 || g1 !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL clear_grant: got grant0=%b load_en0=%b grant1=%b, expected 0000/0/0000", g0, load_en0, g1);
        end
        tick();
        set_idle();
        @(negedge clk);
        vectors++;
        if (count0 !== 6'd0 || wp0 !== 5'd0 || count1 !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL clear_state: got count0=%0d wp0=%0d count1=%0d, expected 0/0/0", count0, wp0, count1);
        end
        tick();
        drive_write(4'b1111, 1'b0);
        @(negedge clk);
        e = wq.pop_front();
        vectors++;
        if (g0 !== e.g0 || wp0 !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL post_clear_grant: got grant=%b wp=%0d, expected grant=%b wp=0", g0, wp0, e.g0);
        end
        tick();
        set_idle();
    endtask

    task automatic test_reset_mid_read();
        wexp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, PASSA, 40 + i, 1);
        for (int c = 0; c < 3; c++) begin
            drive_write(4'b0110, 1'b0);
            @(negedge clk);
            e = wq.pop_front();
            vectors++;
            if (g0 !== e.g0 || wp0 !== e.wp0) begin
                miscompares++;
                $display("[TB] FAIL mid_fill[%0d]: got grant=%b wp=%0d, expected grant=%b wp=%0d", c, g0, wp0, e.g0, e.wp0);
            end
            tick();
        end
        req_valid = '0;
        rd_start  = 1'b1;
        tick();
        rd_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (rd_valid0 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_in_read: got valid=%b, expected 1", rd_valid0);
        end
        tick();
        rd_ready = 1'b1;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        reset_model();
        @(negedge clk);
        vectors++;
        if (rd_valid0 !== 1'b0 || count0 !== 6'd0 || rd_done0 !== 1'b0 || rp0 !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got valid=%b count=%0d done=%b rp=%0d, expected 0/0/0/0", rd_valid0, count0, rd_done0, rp0);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rd_done0 !== 1'b0 || rd_valid0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_no_done: got done=%b valid=%b, expected 0/0", rd_done0, rd_valid0);
        end
        tick();
        set_idle();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) set_req(i, ZERO, 0, 0);
        set_idle();
        reset = 1'b1;
        reset_model();
        test_reset();
        test_round_robin();
        test_single_req();
        test_full_and_wrap();
        test_read_handshake();
        test_empty_read_and_clear();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion by the time limit, expected completion");
        $fatal(1, "[TB] time limit exceeded");
    end

endmodule
